// File: rtl/alu_resp_unit.sv
// alu_resp_unit: handshaked ALU responder with a 2-entry registered result buffer
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   in_valid/ready   request channel carrying op, a, b
//   out_valid/ready  response channel presenting the buffer head
//   out_result       result at the head
//   out_carry        carry/borrow/shifted-out bit at the head
//   out_zero         head result is zero
//   out_ovf          signed overflow for ADD/SUB (only when ALU_OVF_FLAG_EN is defined)
//
// Build option: define ALU_OVF_FLAG_EN to add the out_ovf port and its storage.
module alu_resp_unit #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);
    // Buffer occupancy doubles as the state: EMPTY, ONE, FULL.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'(DEPTH);
    localparam int         MSB   = WIDTH - 1;

    // Entry layout, low to high: result, zero, carry[, ovf]
`ifdef ALU_OVF_FLAG_EN
    localparam int EW = WIDTH + 3;
`else
    localparam int EW = WIDTH + 2;
`endif

    logic [1:0]       count;
    logic [EW-1:0]    head;
    logic [EW-1:0]    tail;
    logic [EW-1:0]    entry;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             push;
    logic             pop;

    assign in_ready  = count != FULL;
    assign out_valid = count != EMPTY;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = ~a;
            3'b100: {carry, res} = sum;
            // The extra bit of the widened difference is the unsigned borrow.
            3'b101: {carry, res} = diff;
            3'b110: {carry, res} = {a, 1'b0};
            default: {res, carry} = {1'b0, a};
        endcase
    end

`ifdef ALU_OVF_FLAG_EN
    logic ovf;

    // Overflow when the result sign disagrees with what the operand signs allow.
    always_comb begin
        ovf = 1'b0;
        if (op == 3'b100)
            ovf = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
        else if (op == 3'b101)
            ovf = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
    end

    assign entry   = {ovf, carry, res == '0, res};
    assign out_ovf = head[WIDTH+2];
`else
    assign entry = {carry, res == '0, res};
`endif

    assign out_result = head[WIDTH-1:0];
    assign out_zero   = head[WIDTH];
    assign out_carry  = head[WIDTH+1];

    // Head always holds the oldest entry; tail is only meaningful when FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (count)
                EMPTY: begin
                    if (push) begin
                        head  <= entry;
                        count <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= entry;
                    end else if (push) begin
                        tail  <= entry;
                        count <= FULL;
                    end else if (pop) begin
                        count <= EMPTY;
                    end
                end
                default: begin
                    if (pop) begin
                        head  <= tail;
                        count <= ONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_resp_unit.sv
// tb_alu_resp_unit: directed self-checking bench for alu_resp_unit (WIDTH=4)
module tb_alu_resp_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic       out_carry;
    logic       out_zero;
`ifdef ALU_OVF_FLAG_EN
    logic       out_ovf;
`endif
    int checks = 0;
    int errors = 0;

    alu_resp_unit #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_carry(out_carry),
        .out_zero(out_zero)
`ifdef ALU_OVF_FLAG_EN
        ,
        .out_ovf(out_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 1'b0;
        op = 'x;
        a  = 'x;
        b  = 'x;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        checks++; if (out_result !== 4'b0000) begin errors++; $display("FAIL reset_result got %b want 0000", out_result); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", out_carry); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", out_zero); end
`ifdef ALU_OVF_FLAG_EN
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_and;
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b000; a = 4'b1101; b = 4'b1011;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and1_valid got %b want 1", out_valid); end
        checks++; if (out_result !== 4'b1001) begin errors++; $display("FAIL and1_result got %b want 1001", out_result); end
        checks++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL and1_flags got c%b z%b want c0 z0", out_carry, out_zero); end
        a = 4'b1100;
        step();
        checks++; if (out_result !== 4'b1000 || out_valid !== 1'b1) begin errors++; $display("FAIL and2_result got %b v%b want 1000 v1", out_result, out_valid); end
        idle_inputs();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL and_drain got %b want 0", out_valid); end
    endtask

    task automatic test_add_wrap;
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b100; a = 4'b1111; b = 4'b0001;
        step();
        idle_inputs();
        checks++; if (out_result !== 4'b0000) begin errors++; $display("FAIL add_wrap_result got %b want 0000", out_result); end
        checks++; if (out_carry !== 1'b1 || out_zero !== 1'b1) begin errors++; $display("FAIL add_wrap_flags got c%b z%b want c1 z1", out_carry, out_zero); end
`ifdef ALU_OVF_FLAG_EN
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL add_wrap_ovf got %b want 0", out_ovf); end
        in_valid = 1'b1; op = 3'b100; a = 4'b0111; b = 4'b0001;
        step();
        checks++; if (out_result !== 4'b1000 || out_ovf !== 1'b1 || out_carry !== 1'b0) begin errors++; $display("FAIL add_ovf got %b o%b c%b want 1000 o1 c0", out_result, out_ovf, out_carry); end
        op = 3'b101; a = 4'b1000; b = 4'b0001;
        step();
        checks++; if (out_result !== 4'b0111 || out_ovf !== 1'b1 || out_carry !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b o%b c%b want 0111 o1 c0", out_result, out_ovf, out_carry); end
        idle_inputs();
`endif
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b010; a = 4'b1010; b = 4'b0110;
        step();
        checks++; if (in_ready !== 1'b1 || out_result !== 4'b1100) begin errors++; $display("FAIL bp_first got r%b %b want r1 1100", in_ready, out_result); end
        op = 3'b101; a = 4'b0011; b = 4'b0101;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        op = 3'b111; a = 4'b1001; b = 4'b0000;
        step();
        checks++; if (in_ready !== 1'b0 || out_result !== 4'b1100 || out_carry !== 1'b0) begin errors++; $display("FAIL bp_held got r%b %b c%b want r0 1100 c0", in_ready, out_result, out_carry); end
        out_ready = 1'b1;
        step();
        checks++; if (out_result !== 4'b1110 || out_carry !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got %b c%b r%b want 1110 c1 r1", out_result, out_carry, in_ready); end
        step();
        idle_inputs();
        checks++; if (out_result !== 4'b0100 || out_carry !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %b c%b v%b want 0100 c1 v1", out_result, out_carry, out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] va [4] = '{4'b0001, 4'b0100, 4'b0000, 4'b1010};
        logic [3:0] vb [4] = '{4'b0010, 4'b1000, 4'b0000, 4'b0101};
        logic [3:0] ve [4] = '{4'b0011, 4'b1100, 4'b0000, 4'b1111};
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b001;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i];
            step();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_result !== ve[i] || out_zero !== (ve[i] == 4'b0000)) begin errors++; $display("FAIL b2b_%0d got v%b r%b %b z%b want v1 r1 %b", i, out_valid, in_ready, out_result, out_zero, ve[i]); end
        end
        idle_inputs();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_stability;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b110; a = 4'b1001; b = 4'b0000;
        step();
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== 4'b0010 || out_carry !== 1'b1) begin errors++; $display("FAIL stable_%0d got v%b %b c%b want v1 0010 c1", i, out_valid, out_result, out_carry); end
            step();
        end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; op = 3'b000; a = 4'b1111; b = 4'b1111;
        step();
        idle_inputs();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got v%b r%b want v0 r1", out_valid, in_ready); end
        checks++; if (out_result !== 4'b0000 || out_carry !== 1'b0 || out_zero !== 1'b0) begin errors++; $display("FAIL mid_reset_out got %b c%b z%b want 0000 c0 z0", out_result, out_carry, out_zero); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'b011; a = 4'b0101; b = 4'b0000;
        step();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_result !== 4'b1010 || out_carry !== 1'b0) begin errors++; $display("FAIL mid_not got v%b %b c%b want v1 1010 c0", out_valid, out_result, out_carry); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_and();
        test_add_wrap();
        test_backpressure();
        test_back_to_back();
        test_stability();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_resp_unit.md
Name: alu_resp_unit

Overview:
Handshaked, registered responder for the ALU operation stimulus. It accepts operand/opcode transactions (A, B, op) on a valid/ready input channel, computes the result and flags, and queues them in a 2-entry result buffer. Results are returned on a valid/ready output channel. This is the response end of the ALU operand interface, so stimulus sources and checkers can stall either side.

Parameters:
WIDTH, 4, operand and result width in bits (minimum 2)
DEPTH, 2, result buffer entries (fixed at 2; no other value is supported)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request transaction present
in_ready  output  1  unit can accept a request this cycle
op  input  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 ADD, 101 SUB (A-B), 110 SHL A by 1, 111 SHR A by 1 (logical)
a  input  WIDTH  operand A
b  input  WIDTH  operand B (ignored for ops 011, 110, 111)
out_valid  output  1  result buffer head valid
out_ready  input  1  consumer accepts head
out_result  output  WIDTH  result at buffer head
out_carry  output  1  ADD carry-out; SUB borrow (1 when A<B unsigned); SHL bit shifted out of MSB; SHR bit shifted out of LSB; 0 for logic ops
out_zero  output  1  1 when out_result == 0

Behaviour:
- Reset (async assert, released synchronously to clk): buffer empty; out_valid=0, out_result=0, out_carry=0, out_zero=0, in_ready=1.
- Input accept: a transfer occurs when in_valid && in_ready at a rising clk edge. Result and flags are computed combinationally from a/b/op and written into the buffer at that edge.
- Latency: out_valid rises the cycle after acceptance when the buffer was empty (1-cycle latency).
- Output transfer: occurs when out_valid && out_ready at a rising clk edge. The head is popped, and the next entry (if any) is presented on the following cycle.
- in_ready = (count < 2). It depends only on registered count, with no combinational path from out_ready. When count==2 and out_ready=1, in_ready stays 0 that cycle; the freed slot is visible the next cycle.
- Simultaneous push and pop (count 1): count stays 1 and the new result becomes head next cycle. With count 0, no pop is possible.
- Buffer states: EMPTY (count 0), ONE (1), FULL (2).
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on push and pop together.
  - FULL -> ONE on pop.
- Ordering: strictly FIFO. No result is dropped or duplicated.
- Output stability: while out_valid && !out_ready, out_result/out_carry/out_zero are held stable.
- Arithmetic: ADD/SUB are computed at WIDTH+1 bits; the result is the low WIDTH bits. Wrap-around is silent except through out_carry.
- Inputs are ignored when in_valid=0. op/a/b may be X when in_valid=0 without corrupting state.
- Reset mid-operation: all buffered results are discarded immediately and outputs return to reset values in the same cycle reset asserts.

Optional Feature:
ALU_OVF_FLAG_EN
- Defined: adds output port out_ovf (1 bit), buffered alongside each result. It is the signed two's-complement overflow for ADD/SUB and 0 for all other ops. Reset value 0.
- Undefined: port absent; no overflow logic or storage.

Test Plan:
- AND: push op=000, a=1101, b=1011 with out_ready=1 -> one cycle later out_valid=1, out_result=1001, out_carry=0, out_zero=0. Repeat with a=1100 -> out_result=1000.
- ADD wrap: a=1111, b=0001, op=100 -> out_result=0000, out_carry=1, out_zero=1. With ALU_OVF_FLAG_EN: a=0111, b=0001 -> out_result=1000, out_ovf=1.
- Backpressure: out_ready=0, push three requests (XOR 1010^0110, SUB 0011-0101, SHR 1001) -> in_ready drops to 0 after the second accept and the third is held. Then raise out_ready -> outputs in order 1100 (carry 0), 1110 (carry 1), 0100 (carry 1).
- Simultaneous push/pop at count 1: continuous in_valid/out_ready with OR ops -> one result per cycle, count stays 1, in_ready stays 1, and results appear in order.
- Stability: hold out_ready=0 for 5 cycles with a SHL 1001 result -> out_result=0010, out_carry=1, unchanged all 5 cycles.
- Reset mid-operation: with the buffer FULL, assert rst between clock edges -> out_valid=0 and in_ready=1 immediately. After release, the first push of NOT 0101 yields 1010 with no stale results.
